// File: rtl/dram_chk_model.sv
// dram_chk_model: clocked multi-bank DRAM array model with RAS/CAS protocol checking
module dram_chk_model #(
  parameter int AW = 10,
  parameter int LANES = 2,
  parameter int NRAS = 2,
  parameter int TRCD = 2,
  parameter int REF_TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic [NRAS-1:0] ras_n,
  input  logic [LANES-1:0] cas_n,
  input  logic we_n,
  input  logic [AW-1:0] a,
  inout  wire  [8*LANES-1:0] d,
  output logic err_cas_no_ras,
  output logic err_multi,
  output logic err_ref,
  output logic [15:0] trcd_viol,
  output logic [15:0] ref_cnt
);
  localparam int DW = 8 * LANES;
  localparam int BW = NRAS > 1 ? $clog2(NRAS) : 1;
  localparam logic [15:0] TR = 16'(TRCD);
  localparam logic [31:0] RT = 32'(REF_TIMEOUT);
  typedef enum logic [1:0] {IDLE, ROW, ACT, CBR} st_t;
  st_t [NRAS-1:0] st;
  logic [NRAS-1:0][AW-1:0] row, row_eff;
  logic [NRAS-1:0][15:0] rcd_cnt;
  logic [NRAS-1:0][DW-1:0] rq;
  logic [NRAS-1:0] ras_q, ras_fall, ras_rise, acc, busy;
  logic [LANES-1:0] cas_q, cas_fall, oe;
  logic cas_any, cbr_hold, viol, ref_ev, rd_start, multi;
  logic [7:0] n_acc;
  logic [15:0] n_ref;
  logic [BW-1:0] acc_bank, rd_bank;
  logic [31:0] tmr;
  assign ras_fall = ras_q & ~ras_n;
  assign ras_rise = ~ras_q & ras_n;
  assign cas_fall = cas_q & ~cas_n;
  assign cas_any = |cas_fall;
  assign cbr_hold = |(~cas_q & ~cas_n);
  always_comb begin
    acc = '0;
    busy = '0;
    row_eff = '0;
    n_acc = '0;
    n_ref = '0;
    viol = 1'b0;
    acc_bank = '0;
    for (int b = 0; b < NRAS; b++) begin
      busy[b] = st[b] != IDLE;
      row_eff[b] = st[b] == IDLE ? a : row[b];
      acc[b] = cas_any && (((st[b] == ROW || st[b] == ACT) && !ras_rise[b]) ||
                           (st[b] == IDLE && ras_fall[b] && !cbr_hold));
      n_acc = n_acc + 8'(acc[b]);
      acc_bank = acc[b] ? BW'(b) : acc_bank;
      viol = viol || (acc[b] && (st[b] == IDLE ? TR != 16'd0 : (st[b] == ROW && rcd_cnt[b] + 16'd1 < TR)));
      n_ref = n_ref + 16'((st[b] == IDLE && ras_fall[b] && cbr_hold) || (st[b] == ROW && ras_rise[b]));
    end
    ref_ev = n_ref != 16'd0;
    multi = n_acc > 8'd1;
    rd_start = cas_any && we_n && n_acc == 8'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_q <= '1;
      cas_q <= '1;
      oe <= '0;
      rd_bank <= '0;
      tmr <= '0;
      st <= {NRAS{IDLE}};
      row <= '0;
      rcd_cnt <= '0;
      err_cas_no_ras <= 1'b0;
      err_multi <= 1'b0;
      err_ref <= 1'b0;
      trcd_viol <= '0;
      ref_cnt <= '0;
    end else begin
      ras_q <= ras_n;
      cas_q <= cas_n;
      for (int b = 0; b < NRAS; b++) begin
        if (st[b] == IDLE && ras_fall[b]) begin
          row[b] <= a;
          rcd_cnt[b] <= '0;
          st[b] <= cbr_hold ? CBR : cas_any ? ACT : ROW;
        end else begin
          st[b] <= busy[b] && ras_rise[b] ? IDLE : (st[b] == ROW && cas_any) ? ACT : st[b];
          rcd_cnt[b] <= (st[b] == ROW && rcd_cnt[b] < TR) ? rcd_cnt[b] + 16'd1 : rcd_cnt[b];
        end
      end
      err_cas_no_ras <= err_cas_no_ras || (cas_any && busy == '0 && ras_fall == '0);
      err_multi <= err_multi || multi;
      trcd_viol <= (viol && trcd_viol != 16'hFFFF) ? trcd_viol + 16'd1 : trcd_viol;
      ref_cnt <= ref_cnt + n_ref;
      tmr <= ref_ev ? '0 : tmr == RT ? tmr : tmr + 32'd1;
      err_ref <= err_ref || (!ref_ev && tmr + 32'd1 == RT);
      oe <= rd_start ? ~cas_n : cas_any ? '0 :
            oe & ~cas_n & {LANES{we_n && st[rd_bank] == ACT && !ras_rise[rd_bank]}};
      rd_bank <= rd_start ? acc_bank : rd_bank;
    end
  end
  for (genvar b = 0; b < NRAS; b++) begin : g_bank
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [7:0] mem [2**(2*AW)];
      logic [7:0] q;
      always_ff @(posedge clk) begin
        if (!rst && !we_n && acc[b] && cas_fall[l]) mem[{a, row_eff[b]}] <= d[8*l +: 8];
        if (!rst && rd_start && acc_bank == BW'(b)) q <= mem[{a, row_eff[b]}];
      end
      assign rq[b][8*l +: 8] = q;
    end
  end
  for (genvar l = 0; l < LANES; l++) begin : g_drv
    assign d[8*l +: 8] = oe[l] ? rq[rd_bank][8*l +: 8] : 'z;
  end
endmodule

// File: tb/tb_dram_chk_model.sv
// tb_dram_chk_model: randomized bench comparing dram_chk_model against a transaction-level reference
module tb_dram_chk_model;
  localparam int RT = 4096;
  localparam int TRCD = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] ras_n = '1;
  logic [1:0] cas_n = '1;
  logic we_n = 1'b1;
  logic [9:0] a = '0;
  logic [15:0] tb_d = '0;
  logic tb_oe = 1'b0;
  wire [15:0] d;
  logic err_cas_no_ras, err_multi, err_ref;
  logic [15:0] trcd_viol, ref_cnt;
  int errs = 0, checks = 0, cyc = 0, last_ref = 0, exp_trcd = 0, exp_ref = 0;
  bit exp_ecnr, exp_emulti, exp_eref;
  logic [15:0] mdl [int];
  int pool_b [8];
  logic [9:0] pool_r [8], pool_c [8];
  dram_chk_model #(.AW(10), .LANES(2), .NRAS(2), .TRCD(TRCD), .REF_TIMEOUT(RT)) dut (
    .clk(clk), .rst(rst), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .a(a), .d(d),
    .err_cas_no_ras(err_cas_no_ras), .err_multi(err_multi), .err_ref(err_ref),
    .trcd_viol(trcd_viol), .ref_cnt(ref_cnt)
  );
  assign d = tb_oe ? tb_d : 'z;
  pullup (d);
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int key(input int b, input logic [9:0] r, input logic [9:0] c);
    return (b << 20) | (int'(c) << 10) | int'(r);
  endfunction
  task automatic ref_event();
    if (cyc - last_ref > RT) exp_eref = 1'b1;
    last_ref = cyc;
    exp_ref = (exp_ref + 1) % 65536;
  endtask
  task automatic check_all(input string tag);
    if (cyc - last_ref >= RT) exp_eref = 1'b1;
    check({tag, ".err_cas_no_ras"}, 16'(err_cas_no_ras), 16'(exp_ecnr));
    check({tag, ".err_multi"}, 16'(err_multi), 16'(exp_emulti));
    check({tag, ".err_ref"}, 16'(err_ref), 16'(exp_eref));
    check({tag, ".trcd_viol"}, trcd_viol, 16'(exp_trcd));
    check({tag, ".ref_cnt"}, ref_cnt, 16'(exp_ref));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    ras_n = '1;
    cas_n = '1;
    we_n = 1'b1;
    tb_oe = 1'b0;
    step();
    rst = 1'b0;
    last_ref = cyc;
    exp_trcd = 0;
    exp_ref = 0;
    exp_ecnr = 1'b0;
    exp_emulti = 1'b0;
    exp_eref = 1'b0;
  endtask
  task automatic access(input string tag, input logic [1:0] bm, input logic [9:0] r, input logic [9:0] c,
                        input bit wr, input logic [15:0] wd, input logic [1:0] mask, input int gap);
    logic [15:0] w, exp;
    a = r;
    ras_n = ~bm;
    if (gap > 0) begin
      repeat (gap) step();
      a = c;
    end
    we_n = !wr;
    tb_d = wd;
    tb_oe = wr;
    cas_n = ~mask;
    step();
    if (gap < TRCD) exp_trcd++;
    if (bm == 2'b11) exp_emulti = 1'b1;
    exp = 16'hFFFF;
    for (int b = 0; b < 2; b++) begin
      if (bm[b]) begin
        w = mdl.exists(key(b, r, c)) ? mdl[key(b, r, c)] : 16'h0000;
        if (wr) begin
          if (mask[0]) w[7:0] = wd[7:0];
          if (mask[1]) w[15:8] = wd[15:8];
          mdl[key(b, r, c)] = w;
        end else if (bm != 2'b11) begin
          if (mask[0]) exp[7:0] = w[7:0];
          if (mask[1]) exp[15:8] = w[15:8];
        end
      end
    end
    if (!wr) check({tag, ".d"}, d, exp);
    cas_n = '1;
    we_n = 1'b1;
    tb_oe = 1'b0;
    step();
    if (!wr) check({tag, ".z"}, d, 16'hFFFF);
    ras_n = '1;
    step();
  endtask
  task automatic cbr();
    cas_n = '0;
    step();
    exp_ecnr = 1'b1;
    ras_n[0] = 1'b0;
    step();
    ref_event();
    ras_n = '1;
    step();
    cas_n = '1;
    step();
  endtask
  task automatic ras_only(input int b, input logic [9:0] r);
    a = r;
    ras_n[b] = 1'b0;
    step();
    step();
    ras_n = '1;
    step();
    ref_event();
  endtask
  initial begin
    logic [15:0] w;
    int p, g;
    bit wr;
    logic [1:0] m;
    do_reset();
    check_all("reset");
    check("reset.d", d, 16'hFFFF);
    access("basic.wr", 2'b01, 10'h012, 10'h345, 1'b1, 16'hA55A, 2'b11, 2);
    access("basic.rd", 2'b01, 10'h012, 10'h345, 1'b0, 16'h0000, 2'b11, 2);
    access("mask.wr0", 2'b01, 10'h020, 10'h100, 1'b1, 16'hFFFF, 2'b11, 2);
    access("mask.wr1", 2'b01, 10'h020, 10'h100, 1'b1, 16'h1200, 2'b10, 2);
    access("mask.rd", 2'b01, 10'h020, 10'h100, 1'b0, 16'h0000, 2'b11, 2);
    access("trcd.rd", 2'b01, 10'h012, 10'h345, 1'b0, 16'h0000, 2'b11, 1);
    check_all("trcd");
    access("simul.wr", 2'b10, 10'h0AB, 10'h0AB, 1'b1, 16'h5A5A, 2'b11, 0);
    access("simul.rd", 2'b10, 10'h0AB, 10'h0AB, 1'b0, 16'h0000, 2'b11, 2);
    check_all("simul");
    for (int i = 0; i < 8; i++) begin
      pool_b[i] = int'($urandom_range(0, 1));
      pool_r[i] = 10'($urandom);
      pool_c[i] = 10'($urandom);
      access("init", 2'b01 << pool_b[i], pool_r[i], pool_c[i], 1'b1, 16'($urandom), 2'b11, 2);
    end
    for (int i = 0; i < 40; i++) begin
      p = int'($urandom_range(0, 7));
      wr = 1'($urandom_range(0, 1));
      m = 2'($urandom_range(1, 3));
      g = int'($urandom_range(1, 3));
      access("rand", 2'b01 << pool_b[p], pool_r[p], pool_c[p], wr, 16'($urandom), m, g);
    end
    check_all("rand");
    cbr();
    cbr();
    cbr();
    ras_only(1, 10'h155);
    check_all("refresh");
    repeat (RT - 2) step();
    cbr();
    check_all("ref_edge");
    repeat (RT) step();
    check_all("timeout");
    access("multi.wr", 2'b11, 10'h033, 10'h044, 1'b1, 16'h3C3C, 2'b11, 2);
    access("multi.rd0", 2'b01, 10'h033, 10'h044, 1'b0, 16'h0000, 2'b11, 2);
    access("multi.rd1", 2'b10, 10'h033, 10'h044, 1'b0, 16'h0000, 2'b11, 2);
    access("multi.rd", 2'b11, 10'h033, 10'h044, 1'b0, 16'h0000, 2'b11, 2);
    check_all("multi");
    w = mdl[key(0, 10'h012, 10'h345)];
    a = 10'h012;
    ras_n = 2'b10;
    step();
    step();
    a = 10'h345;
    cas_n = '0;
    step();
    check("rstmid.d", d, w);
    do_reset();
    check("rstmid.z", d, 16'hFFFF);
    check_all("rstmid");
    access("keep.rd", 2'b01, 10'h012, 10'h345, 1'b0, 16'h0000, 2'b11, 2);
    check_all("final");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/dram_chk_model.md
# dram_chk_model

Clocked, parametrised simulation model of an asynchronous-style DRAM array with multiple RAS lines and per-byte CAS lanes, plus protocol checking. It sits in the testbench on the board-level DRAM pins (`ra`, `rd`, `rras*_n`, `r*cas_n`, `rwe_n`) and samples them on the system clock. It stores read/write data per byte lane, recognises CAS-before-RAS and RAS-only refresh, and exposes sticky error flags and counters for the bench to assert on.

## Interface
- `AW`, 10: row/column address width; each bank holds 2^(2*AW) words.
- `LANES`, 2: byte lanes, one CAS line each; data width is 8*LANES.
- `NRAS`, 2: number of RAS lines (banks).
- `TRCD`, 2: minimum clk cycles from sampled RAS fall to sampled CAS fall.
- `REF_TIMEOUT`, 4096: maximum clk cycles allowed between refresh events.

- `clk` in 1: sampling clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ras_n` in NRAS: row strobes, active low.
- `cas_n` in LANES: column strobes per byte lane, bit 0 = low byte.
- `we_n` in 1: write enable, active low.
- `a` in AW: multiplexed row/column address.
- `d` inout 8*LANES: data bus; high-Z unless a valid read is in progress.
- `err_cas_no_ras` out 1: sticky; CAS fall with no bank active (excluding CBR).
- `err_multi` out 1: sticky; more than one bank active on a CAS fall.
- `err_ref` out 1: sticky; refresh interval exceeded REF_TIMEOUT.
- `trcd_viol` out 16: saturating count of tRCD violations.
- `ref_cnt` out 16: wrapping count of refresh events (CBR + RAS-only).

## Operation
- Edge detection: registered copies of `ras_n`/`cas_n`. A fall is prev=1, now=0.
- Per-bank state: IDLE, ROW (row latched, no CAS yet), ACT (at least one CAS fall seen), CBR.
  - IDLE -> ROW on RAS fall with all `cas_n` high. Latch `row<=a` and clear `rcd_cnt`.
  - IDLE -> CBR on RAS fall with any `cas_n` low. Increment `ref_cnt`, restart the refresh timer, latch no row.
  - ROW -> ACT on any CAS fall. Latch `col<=a`. If `rcd_cnt < TRCD`, increment `trcd_viol`.
  - ROW -> IDLE on RAS rise without any CAS: RAS-only refresh. Increment `ref_cnt` and restart the timer.
  - ACT/CBR -> IDLE on RAS rise.
  - ACT stays in ACT on further CAS falls (page mode). Relatch `col` and perform the access.
- Write: on a CAS fall in the cycle `we_n`=0, for each falling lane L, `mem[bank][{a,row}][8L+7:8L] <= d` lane.
- Read: on a CAS fall with `we_n`=1, register `mem[{a,row}]`. Lane L is driven while `cas_n[L]`=0, `we_n`=1 and the bank is in ACT. Other lanes are Z.
- `err_cas_no_ras` sets on a CAS fall when no bank is in ROW/ACT/CBR and no RAS falls in the same cycle.
- `err_multi` sets when a CAS fall occurs with more than one bank in ROW/ACT.
  - Writes go to all such banks.
  - Reads drive nothing (d=Z).
- The refresh timer increments each cycle. When it reaches REF_TIMEOUT, `err_ref` sets.
- `trcd_viol` saturates at 0xFFFF. `ref_cnt` wraps 0xFFFF -> 0.

## Timing
- Reset values:
  - All bank states IDLE.
  - `d`=Z, all err flags 0, `trcd_viol`=0, `ref_cnt`=0.
  - Refresh timer 0, edge registers all 1.
- Memory contents are not cleared by `rst`.
- Reset mid-operation drops any access and releases `d` the cycle after `rst` is sampled high.
- Edge latency: a pin change is recognised on the first rising clk after it.
- Read data appears on `d` one clk after the recognised CAS fall. It releases to Z one clk after CAS rise or RAS rise.
- Simultaneous RAS fall and CAS fall in one sample:
  - This is not CBR.
  - The bank goes IDLE->ROW and then the CAS applies in the same cycle with `rcd_cnt`=0. This counts as a violation if TRCD>0.
- Simultaneous refresh event and timer expiry: the refresh wins; the timer restarts and `err_ref` is not set.

## Test plan
- Write 0xA55A to bank0 at row 0x012, col 0x345 with both lanes, then read it back. Expect `d`=0xA55A one clk after CAS fall, and Z after CAS rise.
- Lane masking:
  - Write 0xFFFF.
  - Write 0x1200 with only `cas_n[1]` low.
  - Read back; expect 0x12FF.
- CAS fall 1 cycle after RAS fall with TRCD=2. Expect `trcd_viol`=1.
- Issue 3 CBR cycles and 1 RAS-only cycle. Expect `ref_cnt`=4, and `err_ref`=0 when the gap is below REF_TIMEOUT.
- Error flags:
  - Hold with no refresh for REF_TIMEOUT cycles; expect `err_ref`=1.
  - Assert `rst`; expect all flags and counters 0 and previously written data still readable.
- Both RAS lines low, then a read CAS. Expect `err_multi`=1 and `d` staying Z.
